// File: rtl/nd_nto1.sv
// nd_nto1 -- N-to-1 message concentrator.
// Arbitrates NI four-phase input channels into a FSZ-deep message FIFO and
// drains the FIFO onto a single four-phase output channel.
//
// Ports
//   i_clk              clock, all state on the rising edge
//   reset              asynchronous active-low reset
//   ready              high from the first edge after reset release
//   rcv_addr/rcv_data  packed per-channel message, channel i at [i*W +: W]
//   rcv_req/rcv_ack    per-channel four-phase handshake
//   snd0_addr/data     output message, held stable while snd0_req=1
//   snd0_req/snd0_ack  output four-phase handshake
//   count              FIFO occupancy (excludes the message in the output reg)

`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif

module nd_nto1 #(
    parameter int NI  = 2,
    parameter int FSZ = `NS_MESSAGE_FIFO_SIZE,
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int ARB = 0
) (
    input  logic                     i_clk,
    input  logic                     reset,
    output logic                     ready,
    input  logic [NI*ASZ-1:0]        rcv_addr,
    input  logic [NI*DSZ-1:0]        rcv_data,
    input  logic [NI-1:0]            rcv_req,
    output logic [NI-1:0]            rcv_ack,
    output logic [ASZ-1:0]           snd0_addr,
    output logic [DSZ-1:0]           snd0_data,
    output logic                     snd0_req,
    input  logic                     snd0_ack,
    output logic [$clog2(FSZ+1)-1:0] count
);
    localparam int PW = $clog2(NI);
    localparam int FW = $clog2(FSZ);
    localparam int CW = $clog2(FSZ+1);

    logic              ready_q, ready_d;
    logic [NI-1:0]     ack_q, ack_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [FW-1:0]     head_q, head_d;
    logic [FW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              sreq_q, sreq_d;
    logic [ASZ-1:0]    saddr_q, saddr_d;
    logic [DSZ-1:0]    sdata_q, sdata_d;

    logic [ASZ-1:0]    mem_addr [FSZ];
    logic [DSZ-1:0]    mem_data [FSZ];

    logic [NI-1:0]     pend;
    logic [NI-1:0]     win_oh;
    logic              hi_found, lo_found, win_found;
    logic [PW-1:0]     hi_idx, lo_idx, win_idx;
    logic [ASZ-1:0]    win_addr;
    logic [DSZ-1:0]    win_data;
    logic              push, pop;

    // Arbitration. lo_* is the lowest pending channel overall; hi_* is the
    // lowest pending channel strictly above ptr. Round-robin takes hi_* and
    // wraps to lo_* when nothing above ptr is pending.
    always_comb begin
        pend     = rcv_req & ~ack_q;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NI - 1; i >= 0; i--) begin
            if (pend[i]) begin
                lo_found = 1'b1;
                lo_idx   = PW'(i);
                if (PW'(i) > ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        win_found = lo_found;
        win_idx   = (ARB == 0 && hi_found) ? hi_idx : lo_idx;

        win_oh   = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NI; i++) begin
            if (win_found && (PW'(i) == win_idx)) begin
                win_oh[i] = 1'b1;
                win_addr  = rcv_addr[i*ASZ +: ASZ];
                win_data  = rcv_data[i*DSZ +: DSZ];
            end
        end
    end

    always_comb begin
        ready_d = 1'b1;
        // A full FIFO refuses the push even when a pop happens the same edge.
        push = ready_q && win_found && (count_q < CW'(FSZ));
        pop  = ready_q && (count_q != '0) && !sreq_q && !snd0_ack;

        ack_d = ack_q & rcv_req;
        if (push) begin
            ack_d = ack_d | win_oh;
        end

        ptr_d = ptr_q;
        if (push && ARB == 0) begin
            ptr_d = win_idx;
        end

        head_d = push ? head_q + FW'(1) : head_q;
        tail_d = pop  ? tail_q + FW'(1) : tail_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        sreq_d  = sreq_q;
        saddr_d = saddr_q;
        sdata_d = sdata_q;
        if (pop) begin
            sreq_d  = 1'b1;
            saddr_d = mem_addr[tail_q];
            sdata_d = mem_data[tail_q];
        end else if (sreq_q && snd0_ack) begin
            sreq_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            ack_q   <= '0;
            ptr_q   <= PW'(NI - 1);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            sreq_q  <= 1'b0;
            saddr_q <= '0;
            sdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            sreq_q  <= sreq_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
        end
    end

    // Message storage carries no reset; occupancy is tracked by count/head/tail.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_addr[head_q] <= win_addr;
            mem_data[head_q] <= win_data;
        end
    end

    assign ready     = ready_q;
    assign rcv_ack   = ack_q;
    assign snd0_addr = saddr_q;
    assign snd0_data = sdata_q;
    assign snd0_req  = sreq_q;
    assign count     = count_q;

endmodule

// File: tb/tb_nd_nto1.sv
module tb_nd_nto1;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main instance: NI=2, FSZ=4
    logic        m_rst;
    logic        m_ready;
    logic [15:0] m_raddr, m_rdata;
    logic [1:0]  m_rreq, m_rack;
    logic [7:0]  m_saddr, m_sdata;
    logic        m_sreq, m_sack;
    logic [2:0]  m_count;

    nd_nto1 #(.NI(2), .FSZ(4), .ASZ(8), .DSZ(8), .ARB(0)) u_main (
        .i_clk(clk), .reset(m_rst), .ready(m_ready),
        .rcv_addr(m_raddr), .rcv_data(m_rdata), .rcv_req(m_rreq), .rcv_ack(m_rack),
        .snd0_addr(m_saddr), .snd0_data(m_sdata), .snd0_req(m_sreq), .snd0_ack(m_sack),
        .count(m_count)
    );

    // Round-robin and fixed-priority instances: NI=4
    logic        r_rst;
    logic        src_en;

    logic        r_ready, f_ready;
    logic [127:0] r_addr, r_data, f_addr, f_data;
    logic [3:0]  r_req, r_ack, f_req, f_ack;
    logic [31:0] r_saddr, r_sdata, f_saddr, f_sdata;
    logic        r_sreq, r_sack, f_sreq, f_sack;
    logic [2:0]  r_count, f_count;

    nd_nto1 #(.NI(4), .FSZ(4), .ASZ(32), .DSZ(32), .ARB(0)) u_rr (
        .i_clk(clk), .reset(r_rst), .ready(r_ready),
        .rcv_addr(r_addr), .rcv_data(r_data), .rcv_req(r_req), .rcv_ack(r_ack),
        .snd0_addr(r_saddr), .snd0_data(r_sdata), .snd0_req(r_sreq), .snd0_ack(r_sack),
        .count(r_count)
    );

    nd_nto1 #(.NI(4), .FSZ(4), .ASZ(32), .DSZ(32), .ARB(1)) u_fp (
        .i_clk(clk), .reset(r_rst), .ready(f_ready),
        .rcv_addr(f_addr), .rcv_data(f_data), .rcv_req(f_req), .rcv_ack(f_ack),
        .snd0_addr(f_saddr), .snd0_data(f_sdata), .snd0_req(f_sreq), .snd0_ack(f_sack),
        .count(f_count)
    );

    logic [2:0] max_cnt = '0;
    always @(negedge clk) if (m_count > max_cnt) max_cnt = m_count;

    task automatic push_msg(input int ch, input logic [7:0] a, input logic [7:0] d);
        bit got = 1'b0;
        m_raddr[ch*8 +: 8] = a;
        m_rdata[ch*8 +: 8] = d;
        m_rreq[ch] = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (m_rack[ch]) got = 1'b1;
        end
        chk("push_timeout", 32'(got), 32'd1);
        m_rreq[ch] = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input logic [7:0] a, input logic [7:0] d, input int dly);
        bit got = m_sreq;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            got = m_sreq;
        end
        chk("pop_timeout", 32'(got), 32'd1);
        repeat (dly) tick();
        chk("pop_addr", 32'(m_saddr), 32'(a));
        chk("pop_data", 32'(m_sdata), 32'(d));
        m_sack = 1'b1;
        tick();
        m_sack = 1'b0;
    endtask

    // Round-robin sources and in-order sink
    int r_seq [4];
    int rr_n = 0;
    initial begin
        r_req = '0; r_addr = '0; r_data = '0; r_sack = 1'b0;
        for (int c = 0; c < 4; c++) r_seq[c] = 0;
        forever begin
            @(posedge clk); #1;
            if (src_en) begin
                for (int c = 0; c < 4; c++) begin
                    if (r_req[c] && r_ack[c]) begin
                        r_req[c] = 1'b0;
                    end else if (!r_req[c] && !r_ack[c]) begin
                        r_addr[c*32 +: 32] = 32'(c);
                        r_data[c*32 +: 32] = 32'(c * 256 + r_seq[c]);
                        r_seq[c]++;
                        r_req[c] = 1'b1;
                    end
                end
            end
            if (r_sreq && !r_sack) begin
                if (rr_n < 12) chk("rr_order", r_sdata, 32'((rr_n % 4) * 256 + rr_n / 4));
                rr_n++;
            end
            r_sack = r_sreq;
        end
    end

    // Fixed-priority sources, sink and grant monitor
    int f_grants = 0;
    logic [3:0] f_pend_prev, f_ack_prev, f_rises;
    initial begin
        f_req = '0; f_addr = '0; f_data = '0; f_sack = 1'b0;
        f_pend_prev = '0; f_ack_prev = '0;
        forever begin
            @(posedge clk); #1;
            f_rises = f_ack & ~f_ack_prev;
            if (f_rises != '0) begin
                chk("fp_grant", 32'(f_rises), 32'(f_pend_prev & (~f_pend_prev + 4'd1)));
                f_grants++;
            end
            if (src_en) begin
                for (int c = 0; c < 4; c++) begin
                    if (f_req[c] && f_ack[c]) begin
                        f_req[c] = 1'b0;
                    end else if (!f_req[c] && !f_ack[c]) begin
                        f_addr[c*32 +: 32] = 32'(c);
                        f_data[c*32 +: 32] = 32'(c);
                        f_req[c] = 1'b1;
                    end
                end
            end
            f_sack = f_sreq;
            f_pend_prev = f_req & ~f_ack;
            f_ack_prev  = f_ack;
        end
    end

    initial begin
        m_rst = 1'b1; r_rst = 1'b1; src_en = 1'b0;
        m_raddr = '0; m_rdata = '0; m_rreq = '0; m_sack = 1'b0;
        #1;
        m_rst = 1'b0; r_rst = 1'b0;
        #1;
        chk("rst_ready", 32'(m_ready), 32'd0);
        chk("rst_ack",   32'(m_rack),  32'd0);
        chk("rst_sreq",  32'(m_sreq),  32'd0);
        chk("rst_count", 32'(m_count), 32'd0);
        repeat (2) tick();
        m_rst = 1'b1;
        tick();
        chk("ready_up",   32'(m_ready), 32'd1);
        chk("idle_count", 32'(m_count), 32'd0);

        // Single message, minimum latency
        m_raddr[7:0] = 8'd3;
        m_rdata[7:0] = 8'h55;
        m_rreq[0] = 1'b1;
        tick();
        chk("single_ack",   32'(m_rack),  32'b01);
        chk("single_sreq0", 32'(m_sreq),  32'd0);
        chk("single_cnt1",  32'(m_count), 32'd1);
        m_rreq[0] = 1'b0;
        tick();
        chk("single_sreq",  32'(m_sreq),  32'd1);
        chk("single_addr",  32'(m_saddr), 32'd3);
        chk("single_data",  32'(m_sdata), 32'h55);
        chk("single_ackfall", 32'(m_rack), 32'd0);
        chk("single_cnt0",  32'(m_count), 32'd0);
        m_sack = 1'b1;
        tick();
        chk("single_reqfall", 32'(m_sreq), 32'd0);
        m_sack = 1'b0;
        tick();

        // Full FIFO: one message in the output register, four buffered, sixth held
        for (int i = 0; i < 5; i++) push_msg(i % 2, 8'h10 + 8'(i), 8'hA0 + 8'(i));
        chk("full_count", 32'(m_count), 32'd4);
        chk("full_sreq",  32'(m_sreq),  32'd1);
        chk("full_data",  32'(m_sdata), 32'hA0);
        m_raddr[15:8] = 8'h15;
        m_rdata[15:8] = 8'hA5;
        m_rreq[1] = 1'b1;
        repeat (4) tick();
        chk("full_held_ack", 32'(m_rack[1]), 32'd0);
        chk("full_held_cnt", 32'(m_count),   32'd4);
        m_sack = 1'b1;
        tick();
        chk("full_reqfall", 32'(m_sreq), 32'd0);
        m_sack = 1'b0;
        tick();
        chk("full_pop_sreq", 32'(m_sreq),    32'd1);
        chk("full_pop_data", 32'(m_sdata),   32'hA1);
        chk("full_pop_cnt",  32'(m_count),   32'd3);
        chk("full_pop_noack", 32'(m_rack[1]), 32'd0);
        tick();
        chk("full_late_ack", 32'(m_rack[1]), 32'd1);
        chk("full_late_cnt", 32'(m_count),   32'd4);
        m_rreq[1] = 1'b0;
        tick();
        for (int i = 1; i < 6; i++) pop_expect(8'h10 + 8'(i), 8'hA0 + 8'(i), 0);
        tick();
        chk("drain_count", 32'(m_count), 32'd0);
        chk("drain_sreq",  32'(m_sreq),  32'd0);

        // Wrap with concurrent push/pop and random output delay
        fork
            begin
                for (int i = 0; i < 12; i++) push_msg(i % 2, 8'h40 + 8'(i), 8'(i * 7 + 1));
            end
            begin
                for (int j = 0; j < 12; j++) pop_expect(8'h40 + 8'(j), 8'(j * 7 + 1), int'($urandom_range(0, 3)));
            end
        join
        tick();
        chk("wrap_count", 32'(m_count), 32'd0);
        chk("max_count_le_fsz", 32'(max_cnt <= 3'd4), 32'd1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) push_msg(i % 2, 8'h70 + 8'(i), 8'hE0 + 8'(i));
        chk("mid_count", 32'(m_count), 32'd2);
        chk("mid_sreq",  32'(m_sreq),  32'd1);
        #3;
        m_rst = 1'b0;
        #1;
        chk("arst_ready", 32'(m_ready), 32'd0);
        chk("arst_sreq",  32'(m_sreq),  32'd0);
        chk("arst_count", 32'(m_count), 32'd0);
        chk("arst_addr",  32'(m_saddr), 32'd0);
        chk("arst_data",  32'(m_sdata), 32'd0);
        chk("arst_ack",   32'(m_rack),  32'd0);
        m_rreq[1] = 1'b1;
        repeat (2) tick();
        chk("rst_ignore_req", 32'(m_rack), 32'd0);
        m_rreq[1] = 1'b0;
        m_rst = 1'b1;
        tick();
        chk("rerelease_ready", 32'(m_ready), 32'd1);
        repeat (4) tick();
        chk("no_stale_sreq",  32'(m_sreq),  32'd0);
        chk("no_stale_count", 32'(m_count), 32'd0);
        push_msg(1, 8'h99, 8'h77);
        pop_expect(8'h99, 8'h77, 0);

        // Arbitration instances
        src_en = 1'b1;
        repeat (2) tick();
        r_rst = 1'b1;
        repeat (60) tick();
        chk("rr_msgs_seen",   32'(rr_n >= 12),     32'd1);
        chk("fp_grants_seen", 32'(f_grants >= 8),  32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
